// File: rtl/rst_seq_if.sv
// Memory-mapped register bus for the reset sequencer: strobe, write enable,
// write/read data and acknowledge.
interface rst_seq_if;
  logic        stb;
  logic        we;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;

  modport master (output stb, we, data_in, input data_out, ack);
  modport slave  (input stb, we, data_in, output data_out, ack);
endinterface

// File: rtl/rst_seq.sv
// Reset sequencer: arbitrates button/system/watchdog/software requests into a fixed-length rst_out pulse.
// Optional button debounce filter is enabled by defining RST_SEQ_BTN_DEBOUNCE_EN.
module rst_seq #(
  parameter int RST_CYCLES = 16,
  parameter int DB_CYCLES  = 50000
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      btn,
  input  logic      sys_rst_req,
  input  logic      wd_rst_req,
  rst_seq_if.slave  bus,
  output logic      rst_out
);

  localparam int CW = $clog2(RST_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(RST_CYCLES - 1);

  typedef enum logic [1:0] {PWR, IDLE, ASSERT, HOLDOFF} state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          accept;

  logic          btn_meta;
  logic          btn_sync;
  logic          btn_lvl;
  logic          btn_prev;
  logic          btn_rise;

  logic [3:0]    cause;
  logic [2:0]    mask;
  logic [15:0]   rst_cnt;
  logic [3:0]    req;
  logic          wr;
  logic          rd;
  logic          cnt_clr;
  logic          unused_data_bits;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= btn;
      btn_sync <= btn_meta;
    end
  end

`ifdef RST_SEQ_BTN_DEBOUNCE_EN
  localparam int DW = $clog2(DB_CYCLES + 1);

  logic [DW-1:0] db_cnt;
  logic          btn_filt;

  // The filtered level only follows the synchronized button after it has
  // disagreed with it for DB_CYCLES consecutive cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt   <= '0;
      btn_filt <= 1'b0;
    end else if (btn_sync == btn_filt) begin
      db_cnt   <= '0;
    end else if (db_cnt == DW'(DB_CYCLES - 1)) begin
      db_cnt   <= '0;
      btn_filt <= btn_sync;
    end else begin
      db_cnt   <= db_cnt + 1'b1;
    end
  end

  assign btn_lvl = btn_filt;
`else
  localparam int unused_db_cycles = DB_CYCLES;

  assign btn_lvl = btn_sync;
`endif

  always_ff @(posedge clk) begin
    if (rst) btn_prev <= 1'b0;
    else     btn_prev <= btn_lvl;
  end

  assign btn_rise = btn_lvl & ~btn_prev;

  assign wr      = bus.stb & bus.we & (state != PWR);
  assign rd      = bus.stb & ~bus.we;
  assign cnt_clr = wr & bus.data_in[1];

  // Software requests bypass the mask so firmware can always force a reset.
  assign req = {wr & bus.data_in[0],
                wd_rst_req  & ~mask[2],
                sys_rst_req & ~mask[1],
                btn_rise    & ~mask[0]};

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    case (state)
      PWR: begin
        if (cnt == LAST) begin
          next_state = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next   = cnt + 1'b1;
        end
      end
      IDLE: begin
        if (req != 4'b0000) begin
          next_state = ASSERT;
          accept     = 1'b1;
          cnt_next   = '0;
        end
      end
      ASSERT: begin
        if (cnt == LAST) begin
          next_state = HOLDOFF;
          cnt_next   = '0;
        end else begin
          cnt_next   = cnt + 1'b1;
        end
      end
      HOLDOFF: begin
        if (cnt == CW'(1)) begin
          next_state = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next   = cnt + 1'b1;
        end
      end
      default: begin
        next_state = PWR;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= PWR;
      cnt     <= '0;
      rst_out <= 1'b1;
    end else begin
      state   <= next_state;
      cnt     <= cnt_next;
      rst_out <= (next_state == PWR) || (next_state == ASSERT);
    end
  end

  // An accepted request wins over a same-cycle counter clear, leaving a count of one.
  always_ff @(posedge clk) begin
    if (rst) begin
      cause   <= 4'b0000;
      mask    <= 3'b000;
      rst_cnt <= 16'h0000;
    end else begin
      if (wr) mask <= bus.data_in[10:8];
      if (accept) begin
        cause <= req;
        if (cnt_clr)                   rst_cnt <= 16'h0001;
        else if (rst_cnt != 16'hFFFF)  rst_cnt <= rst_cnt + 16'h0001;
      end else if (cnt_clr) begin
        rst_cnt <= 16'h0000;
      end
    end
  end

  assign bus.ack      = bus.stb;
  assign bus.data_out = rd ? {rst_cnt, 4'b0000, 1'b0, mask, 4'b0000, cause} : 32'h0000_0000;

  assign unused_data_bits = ^{bus.data_in[31:11], bus.data_in[7:2]};

endmodule
